// File: rtl/vga_pkg.sv
// Shared VGA sprite-pipeline definitions: ROM geometry, sprite size and the
// arbiter state encoding used by sprite_rom_arbiter.
package vga_pkg;

  localparam int ADDR_W   = 12;
  localparam int RGB_W    = 12;
  localparam int SPRITE_W = 48;
  localparam int SPRITE_H = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Requester-index width; a single requester still needs a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Bus between the sprite drawers, the shared sprite ROM and the arbiter.
// The arbiter uses the slave modport; drawers/ROM side use master.
interface sprite_rom_arbiter_if
  import vga_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = vga_pkg::ADDR_W,
  parameter int RGB_W   = vga_pkg::RGB_W,
  parameter int ID_W    = id_width(NUM_REQ)
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_addr;
  logic [RGB_W-1:0]          rom_rgb;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [RGB_W-1:0]          rsp_rgb;

  modport slave (
    input  req, req_addr, rom_rgb,
    output gnt, rom_addr, rsp_valid, rsp_id, rsp_rgb
  );

  modport master (
    output req, req_addr, rom_rgb,
    input  gnt, rom_addr, rsp_valid, rsp_id, rsp_rgb
  );

endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester with
// (req & mask) set, searching ptr, ptr+1, ... modulo NUM_REQ.
module sprite_rom_arbiter_rr_pick
  import vga_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[j] && mask[j]) begin
        onehot[j] = 1'b1;
        idx       = ID_W'(j);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM port among NUM_REQ drawers with
// bounded-burst round-robin and returns id-tagged RGB aligned to ROM latency.
module sprite_rom_arbiter
  import vga_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = vga_pkg::ADDR_W,
  parameter int RGB_W     = vga_pkg::RGB_W,
  parameter int ROM_LAT   = 1,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               rst,
  sprite_rom_arbiter_if.slave bus
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t          state;
  logic [ID_W-1:0]     owner;
  logic [ID_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]    burst_cnt;

  logic [NUM_REQ-1:0]  owner_onehot;
  logic                owner_req;
  logic                burst_full;

  logic [NUM_REQ-1:0]  all_onehot, oth_onehot;
  logic [ID_W-1:0]     all_idx, oth_idx;
  logic                all_any, oth_any;

  logic [NUM_REQ-1:0]  gnt_c;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_any;
  logic                owner_change;

  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  assign owner_onehot = NUM_REQ'(1) << owner;
  assign owner_req    = |(bus.req & owner_onehot);
  assign burst_full   = (burst_cnt == CNT_W'(MAX_BURST));

  sprite_rom_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick_all (
    .req    (bus.req),
    .mask   ({NUM_REQ{1'b1}}),
    .ptr    (rr_ptr),
    .onehot (all_onehot),
    .idx    (all_idx),
    .any    (all_any)
  );

  // Same search, excluding the current owner, for the burst-limit handover.
  sprite_rom_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick_oth (
    .req    (bus.req),
    .mask   (~owner_onehot),
    .ptr    (rr_ptr),
    .onehot (oth_onehot),
    .idx    (oth_idx),
    .any    (oth_any)
  );

  always_comb begin
    gnt_c        = '0;
    gnt_idx      = '0;
    gnt_any      = 1'b0;
    owner_change = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (all_any) begin
            gnt_c   = all_onehot;
            gnt_idx = all_idx;
            gnt_any = 1'b1;
          end
        end
        BURST: begin
          if (owner_req && (!burst_full || !oth_any)) begin
            gnt_c   = owner_onehot;
            gnt_idx = owner;
            gnt_any = 1'b1;
          end else if (owner_req) begin
            gnt_c        = oth_onehot;
            gnt_idx      = oth_idx;
            gnt_any      = 1'b1;
            owner_change = 1'b1;
          end else if (all_any) begin
            gnt_c        = all_onehot;
            gnt_idx      = all_idx;
            gnt_any      = 1'b1;
            owner_change = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            state     <= BURST;
            owner     <= gnt_idx;
            burst_cnt <= CNT_W'(1);
          end
        end
        BURST: begin
          if (!gnt_any) begin
            state  <= IDLE;
            rr_ptr <= ptr_inc(owner);
          end else if (owner_change) begin
            owner     <= gnt_idx;
            burst_cnt <= CNT_W'(1);
            rr_ptr    <= ptr_inc(owner);
          end else if (!burst_full) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [ROM_LAT-1:0]           tag_valid;
  logic [ROM_LAT-1:0][ID_W-1:0] tag_id;

  // NOTE: the tag pipeline is control state, not storage, so it is reset;
  // that is what drops responses for beats in flight across a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid[0] <= gnt_any;
      tag_id[0]    <= gnt_idx;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  always_comb begin
    bus.rom_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) bus.rom_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.rsp_valid = tag_valid[ROM_LAT-1];
  assign bus.rsp_id    = tag_id[ROM_LAT-1];
  assign bus.rsp_rgb   = bus.rsp_valid ? bus.rom_rgb : '0;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench: a 2-requester/latency-1 arbiter and a 3-requester/latency-3
// arbiter, each against its own ROM model and expected response pipeline.
module tb_sprite_rom_arbiter;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int n      = 0;

  sprite_rom_arbiter_if #(.NUM_REQ(2)) bus1 ();
  sprite_rom_arbiter_if #(.NUM_REQ(3)) bus3 ();

  sprite_rom_arbiter #(.NUM_REQ(2), .ROM_LAT(1), .MAX_BURST(16)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  sprite_rom_arbiter #(.NUM_REQ(3), .ROM_LAT(3), .MAX_BURST(16)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  function automatic logic [11:0] rom_word(input logic [11:0] a);
    return {a[3:0], a[11:4]} ^ 12'h5A5;
  endfunction

  // Sprite ROM models: address registered, data ROM_LAT cycles later.
  logic [11:0] r3_a, r3_d;
  always @(posedge clk) begin
    bus1.rom_rgb <= rom_word(bus1.rom_addr);
    r3_a         <= bus3.rom_addr;
    r3_d         <= rom_word(r3_a);
    bus3.rom_rgb <= r3_d;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected response pipelines.
  logic        m1_v;
  logic        m1_id;
  logic [11:0] m1_a;
  logic        m3_v  [3];
  logic [1:0]  m3_id [3];
  logic [11:0] m3_a  [3];

  task automatic step1(input logic r, input logic [1:0] rq, input logic [1:0] eg, input string tag);
    logic [11:0] a0, a1, ea;
    @(posedge clk);
    #1;
    a0 = 12'h100 + 12'(n);
    a1 = 12'hA00 + 12'(n);
    n++;
    rst           = r;
    bus1.req      = rq;
    bus1.req_addr = {a1, a0};
    #1;
    ea = eg[0] ? a0 : (eg[1] ? a1 : 12'h000);
    check({tag, ".gnt"},       32'(bus1.gnt),       32'(eg));
    check({tag, ".rom_addr"},  32'(bus1.rom_addr),  32'(ea));
    check({tag, ".rsp_valid"}, 32'(bus1.rsp_valid), 32'(m1_v));
    check({tag, ".rsp_id"},    32'(bus1.rsp_id),    32'(m1_id));
    check({tag, ".rsp_rgb"},   32'(bus1.rsp_rgb),   32'(m1_v ? rom_word(m1_a) : 12'h000));
    if (r) begin
      m1_v = 1'b0; m1_id = 1'b0; m1_a = '0;
    end else begin
      m1_v = |eg; m1_id = eg[1]; m1_a = ea;
    end
  endtask

  task automatic step3(input logic r, input logic [2:0] rq, input logic [2:0] eg, input string tag);
    logic [11:0] a0, a1, a2, ea;
    logic [1:0]  eid;
    @(posedge clk);
    #1;
    a0 = 12'h1A0 + 12'(n);
    a1 = 12'h2B0 + 12'(n);
    a2 = 12'h3C0 + 12'(n);
    n++;
    rst           = r;
    bus3.req      = rq;
    bus3.req_addr = {a2, a1, a0};
    #1;
    ea  = eg[0] ? a0 : (eg[1] ? a1 : (eg[2] ? a2 : 12'h000));
    eid = eg[1] ? 2'd1 : (eg[2] ? 2'd2 : 2'd0);
    check({tag, ".gnt"},       32'(bus3.gnt),       32'(eg));
    check({tag, ".rom_addr"},  32'(bus3.rom_addr),  32'(ea));
    check({tag, ".rsp_valid"}, 32'(bus3.rsp_valid), 32'(m3_v[2]));
    check({tag, ".rsp_id"},    32'(bus3.rsp_id),    32'(m3_id[2]));
    check({tag, ".rsp_rgb"},   32'(bus3.rsp_rgb),   32'(m3_v[2] ? rom_word(m3_a[2]) : 12'h000));
    for (int s = 2; s > 0; s--) begin
      m3_v[s] = r ? 1'b0 : m3_v[s-1];
      m3_id[s] = r ? 2'd0 : m3_id[s-1];
      m3_a[s] = r ? 12'h000 : m3_a[s-1];
    end
    m3_v[0]  = r ? 1'b0 : |eg;
    m3_id[0] = r ? 2'd0 : eid;
    m3_a[0]  = r ? 12'h000 : ea;
  endtask

  initial begin
    bus1.req = '0; bus1.req_addr = '0;
    bus3.req = '0; bus3.req_addr = '0;
    m1_v = 1'b0; m1_id = 1'b0; m1_a = '0;
    for (int s = 0; s < 3; s++) begin
      m3_v[s] = 1'b0; m3_id[s] = 2'd0; m3_a[s] = '0;
    end
    repeat (2) @(posedge clk);

    // Reset holds grants off even with requests present.
    step1(1'b1, 2'b11, 2'b00, "rst_hold");
    step1(1'b1, 2'b11, 2'b00, "rst_hold");

    // Single requester, four beats with changing addresses.
    for (int i = 0; i < 4; i++) step1(1'b0, 2'b01, 2'b01, "single");
    step1(1'b0, 2'b00, 2'b00, "idle_gap");
    step1(1'b0, 2'b00, 2'b00, "idle_gap");

    // Contention from a fresh reset: 16 beats to 0, then 1 with no bubble.
    step1(1'b1, 2'b00, 2'b00, "rst");
    for (int i = 0; i < 16; i++) step1(1'b0, 2'b11, 2'b01, "burst0");
    step1(1'b0, 2'b11, 2'b10, "burst_switch");
    step1(1'b0, 2'b00, 2'b00, "idle_after_burst");
    step1(1'b0, 2'b00, 2'b00, "idle_after_burst");

    // Early release: owner 0 drops after 3 beats, 1 granted same cycle.
    for (int i = 0; i < 3; i++) step1(1'b0, 2'b11, 2'b01, "pre_release");
    step1(1'b0, 2'b10, 2'b10, "release");
    step1(1'b0, 2'b10, 2'b10, "owner1");

    // Reset mid-burst of owner 1; rr_ptr restarts at 0.
    step1(1'b1, 2'b10, 2'b00, "rst_mid");
    step1(1'b0, 2'b11, 2'b01, "after_rst");
    step1(1'b0, 2'b00, 2'b00, "drain");
    step1(1'b0, 2'b00, 2'b00, "drain");

    // Three requesters, latency 3: alternating single beats.
    step3(1'b0, 3'b001, 3'b001, "lat3_b0");
    step3(1'b0, 3'b010, 3'b010, "lat3_b1");
    step3(1'b0, 3'b100, 3'b100, "lat3_b2");
    for (int i = 0; i < 4; i++) step3(1'b0, 3'b000, 3'b000, "lat3_drain");

    // Reset with a beat in flight: its response must never appear.
    step3(1'b0, 3'b011, 3'b001, "lat3_inflight");
    step3(1'b1, 3'b011, 3'b000, "lat3_rst");
    step3(1'b0, 3'b110, 3'b010, "lat3_after_rst");
    for (int i = 0; i < 4; i++) step3(1'b0, 3'b000, 3'b000, "lat3_tail");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
